fetch_unit: RTL

- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and runs a request/acknowledge handshake with instruction memory.
- Latches the fetched word and presents opcode[5:0] plus the full instruction to decode.
- Computes the next PC from the resolved Jmp/Branch/Bneq/zero/jr controls when the datapath signals instruction completion.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/next_pc_logic.sv | 35 +++
 rtl/fetch_unit.sv | 81 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state type, opcode and funct constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StHalt
  } fetch_state_e;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode outputs, resolved controls.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        ex_done;
  logic        jmp;
  logic        branch;
  logic        bneq;
  logic        zero;
  logic        jr;
  logic [31:0] jr_addr;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc_out, link_addr, halted,
    input  imem_ack, imem_rdata, ex_done, jmp, branch, bneq, zero, jr, jr_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc_out, link_addr, halted,
    output imem_ack, imem_rdata, ex_done, jmp, branch, bneq, zero, jr, jr_addr
  );

endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jr > jmp > taken branch > pc+4.
module next_pc_logic (
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_i,
  input  logic        jmp_i,
  input  logic        branch_i,
  input  logic        bneq_i,
  input  logic        zero_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc4_o,
  output logic        misalign_o
);

  logic [31:0] br_off;
  logic        taken;

  assign pc4_o      = pc_i + 32'd4;
  assign br_off     = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
  assign taken      = branch_i & (zero_i ^ bneq_i);
  assign misalign_o = jr_i & (jr_addr_i[1:0] != 2'b00);

  always_comb begin
    next_pc_o = pc4_o;
    if (jr_i) begin
      next_pc_o = jr_addr_i;
    end else if (jmp_i) begin
      next_pc_o = {pc4_o[31:28], instr_i, 2'b00};
    end else if (taken) begin
      next_pc_o = pc4_o + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem handshake FSM and latched instruction.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master fu_io
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc, pc4;
  logic         misalign;

  next_pc_logic u_next_pc (
    .pc_i       (pc_q),
    .instr_i    (instr_q[25:0]),
    .jmp_i      (fu_io.jmp),
    .branch_i   (fu_io.branch),
    .bneq_i     (fu_io.bneq),
    .zero_i     (fu_io.zero),
    .jr_i       (fu_io.jr),
    .jr_addr_i  (fu_io.jr_addr),
    .next_pc_o  (next_pc),
    .pc4_o      (pc4),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (fu_io.imem_ack) begin
          instr_d = fu_io.imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // A misaligned jr target stops the stage with the PC left on the jr itself.
        if (fu_io.ex_done) begin
          if (misalign) begin
            state_d = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign fu_io.imem_req    = (state_q == StFetch);
  assign fu_io.imem_addr   = pc_q;
  assign fu_io.instr       = instr_q;
  assign fu_io.opcode      = instr_q[31:26];
  assign fu_io.instr_valid = (state_q == StIssue);
  assign fu_io.pc_out      = pc_q;
  assign fu_io.link_addr   = pc4;
  assign fu_io.halted      = (state_q == StHalt);

endmodule
